// File: rtl/md_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_ctrl_pkg;

   localparam int unsigned DATA_W        = 32;
   localparam int unsigned MD_DIV_CYCLES = 32;
   localparam logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // Magnitude of an operand; unsigned operands pass through untouched.
   function automatic logic [DATA_W-1:0] md_mag(input logic [DATA_W-1:0] x,
                                                input logic              is_signed);
      return (is_signed && x[DATA_W-1]) ? DATA_W'(-x) : x;
   endfunction

endpackage

// File: rtl/div_radix2.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and produces one quotient bit.
module div_radix2
   import md_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quo_i,
   input  logic [DATA_W-1:0] dvs_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] quo_o
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   always_comb begin
      shifted = {rem_i, quo_i[DATA_W-1]};
      diff    = shifted - {1'b0, dvs_i};
      if (diff[DATA_W]) begin
         rem_o = shifted[DATA_W-1:0];
         quo_o = {quo_i[DATA_W-2:0], 1'b0};
      end else begin
         rem_o = diff[DATA_W-1:0];
         quo_o = {quo_i[DATA_W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide sequencer: latches operands, stalls until the result
// is ready, holds the result while the pipeline is held, and cancels on flush.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_is_div,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   input  logic              stall_ext,
   output logic              stall_o,
   output logic              res_valid,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

   md_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] dvs_q;
   logic              sgn_q;
   logic              qneg_q;
   logic              rneg_q;
   logic              res_valid_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   logic [DATA_W-1:0]   rem_nxt;
   logic [DATA_W-1:0]   quo_nxt;
   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] b_ext;
   logic [2*DATA_W-1:0] prod;
   logic                accept;

   // Multiply: quo_q/dvs_q hold the raw operands; low 64 bits of the
   // extended product are correct for both signed and unsigned.
   assign a_ext = sgn_q ? {{DATA_W{quo_q[DATA_W-1]}}, quo_q} : {{DATA_W{1'b0}}, quo_q};
   assign b_ext = sgn_q ? {{DATA_W{dvs_q[DATA_W-1]}}, dvs_q} : {{DATA_W{1'b0}}, dvs_q};
   assign prod  = a_ext * b_ext;

   div_radix2 u_div_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (rem_nxt),
      .quo_o (quo_nxt)
   );

   assign accept  = (state_q == MD_IDLE) && req_valid && !flush;
   // Gated by reset so the hazard unit sees no stall while reset is asserted.
   assign stall_o = rst && !flush &&
                    (accept || (state_q == MD_MUL) || (state_q == MD_DIV));

   assign res_valid = res_valid_q;
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         sgn_q       <= 1'b0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         res_valid_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else if (flush) begin
         state_q     <= MD_IDLE;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         case (state_q)
            MD_IDLE: begin
               if (req_valid) begin
                  sgn_q  <= req_signed;
                  qneg_q <= req_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                  rneg_q <= req_signed && src_a[DATA_W-1];
                  if (!req_is_div) begin
                     quo_q   <= src_a;
                     dvs_q   <= src_b;
                     state_q <= MD_MUL;
                  end else if (src_b == '0) begin
                     hi_q        <= src_a;
                     lo_q        <= DIV0_LO;
                     res_valid_q <= 1'b1;
                     state_q     <= MD_DONE;
                  end else begin
                     quo_q   <= md_mag(src_a, req_signed);
                     dvs_q   <= md_mag(src_b, req_signed);
                     rem_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= MD_DIV;
                  end
               end
            end
            MD_MUL: begin
               hi_q        <= prod[2*DATA_W-1:DATA_W];
               lo_q        <= prod[DATA_W-1:0];
               res_valid_q <= 1'b1;
               state_q     <= MD_DONE;
            end
            MD_DIV: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                  hi_q        <= rneg_q ? DATA_W'(-rem_nxt) : rem_nxt;
                  lo_q        <= qneg_q ? DATA_W'(-quo_nxt) : quo_nxt;
                  res_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= MD_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            MD_DONE: begin
               // Held result stays put while the pipeline is stalled elsewhere.
               if (!stall_ext) begin
                  res_valid_q <= 1'b0;
                  state_q     <= MD_IDLE;
               end
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

endmodule
